// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: shifts one bit per cycle under FSM control and
// reports completion with a start/busy/done handshake.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             shamt_src,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             op_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [SHW-1:0] count;
  logic [SHW-1:0] amount;
  logic [1:0]     op_q;
  logic           err_q;
  logic           accept;
  logic           bypass;
  logic           b_unused;

  // Only the two amount fields of B matter; the rest of the word is ignored.
  assign b_unused = ^{B[WIDTH-1:SHW+6], B[5:SHW]};

  assign amount = shamt_src ? B[SHW-1:0] : B[6 +: SHW];
  assign accept = (state == IDLE) && start;
  assign bypass = (amount == '0) || (op == 2'b11);

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign op_err = (state == DONE) && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bypass ? DONE : SHIFT;
      SHIFT:   if (count == SHW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept, so input changes mid-operation are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res   <= '0;
      count <= '0;
      op_q  <= 2'b00;
      err_q <= 1'b0;
    end else if (accept) begin
      res   <= A;
      count <= amount;
      op_q  <= op;
      err_q <= (op == 2'b11);
    end else if (state == SHIFT) begin
      case (op_q)
        2'b00:   res <= {res[WIDTH-2:0], 1'b0};
        2'b01:   res <= {1'b0, res[WIDTH-1:1]};
        2'b10:   res <= {res[WIDTH-1], res[WIDTH-1:1]};
        default: res <= res;
      endcase
      count <= count - SHW'(1);
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a cycle-level reference model checked
// every cycle, plus directed operations with hand-computed results and latencies.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        shamt_src = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, op_err;
  logic [31:0] res;

  int numChecks = 0;
  int numFail   = 0;
  bit checkEn   = 1'b0;

  shift_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .shamt_src(shamt_src),
    .A(A), .B(B), .busy(busy), .done(done), .res(res), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] shiftModel(input logic [31:0] a, input logic [1:0] o, input int s);
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  // Reference model: an accepted request at edge k finishes at edge k+n
  // (or k for n==0 / reserved op); after edge k+i res is the input shifted by i.
  int          edgeNum   = 0;
  bit          mActive   = 1'b0;
  int          mK        = 0;
  int          mN        = 0;
  int          mDoneEdge = -10;
  logic [31:0] mA        = '0;
  logic [1:0]  mOp       = 2'b00;
  bit          mErr      = 1'b0;
  logic [31:0] expRes    = '0;
  logic        expBusy   = 1'b0;
  logic        expDone   = 1'b0;
  logic        expErr    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive   = 1'b0;
      mDoneEdge = -10;
      expRes    = '0;
      expBusy   = 1'b0;
      expDone   = 1'b0;
      expErr    = 1'b0;
    end else begin
      edgeNum++;
      if (!(mActive && (edgeNum - 1 <= mDoneEdge)) && start) begin
        mActive   = 1'b1;
        mA        = A;
        mOp       = op;
        mN        = shamt_src ? int'(B[4:0]) : int'(B[10:6]);
        mErr      = (op == 2'b11);
        mK        = edgeNum;
        mDoneEdge = (mErr || mN == 0) ? edgeNum : edgeNum + mN;
      end
      if (mActive) begin
        expRes  = shiftModel(mA, mOp, (edgeNum - mK < mN) ? edgeNum - mK : mN);
        expBusy = (edgeNum <= mDoneEdge);
        expDone = (edgeNum == mDoneEdge);
        expErr  = expDone && mErr;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_busy",   32'(busy),   32'(expBusy));
      checkOutput("model_done",   32'(done),   32'(expDone));
      checkOutput("model_op_err", 32'(op_err), 32'(expErr));
      checkOutput("model_res",    res,         expRes);
    end
  end

  // Issues one request and waits for done; inputs are scrambled while busy,
  // and optionally a competing start is pulsed mid-operation.
  task automatic applyStimulus(input [1:0] o, input logic s, input [31:0] a, input [31:0] b,
                               input bit dropPulse,
                               output [31:0] r, output int lat, output logic e);
    op = o; shamt_src = s; A = a; B = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3)); shamt_src = 1'($urandom_range(0, 1));
      if (dropPulse && lat == 1) begin
        A = 32'h1234; B = 32'h0000_0080; op = 2'b00; start = 1'b1;
      end
      @(posedge clk); #2;
      start = 1'b0;
      lat++;
    end
    if (!done) begin
      numChecks++; numFail++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", lat);
    end
    r = res;
    e = op_err;
    @(posedge clk); #2;
  endtask

  logic [31:0] r;
  int          lat;
  logic        e;
  int          doneSeen;

  initial begin
    @(posedge clk); @(posedge clk); #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_res",  res,       32'd0);
    rst = 1'b0;
    checkEn = 1'b1;
    @(posedge clk); #2;

    // Reset in the middle of a long shift.
    op = 2'b01; shamt_src = 1'b1; A = 32'hFFFF0000; B = 32'd20; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("midshift_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_res",  res,       32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (done) doneSeen++;
    end
    checkOutput("no_done_after_rst", 32'(doneSeen), 32'd0);

    applyStimulus(2'b01, 1'b0, 32'h80000000, 32'd4 << 6, 1'b0, r, lat, e);
    checkOutput("srl4_res", r, 32'h08000000);
    checkOutput("srl4_lat", 32'(lat), 32'd4);
    checkOutput("srl4_err", 32'(e), 32'd0);

    applyStimulus(2'b10, 1'b1, 32'hF0000000, 32'd31, 1'b0, r, lat, e);
    checkOutput("sra31_res", r, 32'hFFFFFFFF);
    checkOutput("sra31_lat", 32'(lat), 32'd31);
    applyStimulus(2'b01, 1'b1, 32'hF0000000, 32'd31, 1'b0, r, lat, e);
    checkOutput("srl31_res", r, 32'h00000001);
    checkOutput("srl31_lat", 32'(lat), 32'd31);

    applyStimulus(2'b00, 1'b0, 32'h00000001, 32'd31 << 6, 1'b0, r, lat, e);
    checkOutput("sll31_res", r, 32'h80000000);
    checkOutput("sll31_lat", 32'(lat), 32'd31);
    applyStimulus(2'b00, 1'b0, 32'h00000001, 32'hFFFF_F83F, 1'b0, r, lat, e);
    checkOutput("n0_res", r, 32'h00000001);
    checkOutput("n0_lat", 32'(lat), 32'd0);
    checkOutput("n0_err", 32'(e), 32'd0);

    applyStimulus(2'b01, 1'b0, 32'h80000000, 32'd4 << 6, 1'b1, r, lat, e);
    checkOutput("drop_res", r, 32'h08000000);
    checkOutput("drop_lat", 32'(lat), 32'd4);
    applyStimulus(2'b00, 1'b1, 32'h00000003, 32'd2, 1'b0, r, lat, e);
    checkOutput("after_done_res", r, 32'h0000000C);
    checkOutput("after_done_lat", 32'(lat), 32'd2);

    applyStimulus(2'b11, 1'b1, 32'hDEADBEEF, 32'd5, 1'b0, r, lat, e);
    checkOutput("rsvd_res", r, 32'hDEADBEEF);
    checkOutput("rsvd_lat", 32'(lat), 32'd0);
    checkOutput("rsvd_err", 32'(e), 32'd1);
    checkOutput("rsvd_err_clear", 32'(op_err), 32'd0);

    repeat (3) @(posedge clk);
    #2;
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
    $finish;
  end

endmodule
